// File: rtl/instr_trace_buffer.sv
// Instruction trace capture buffer: records {pc, instr, cycle} whenever the core PC changes
// while tracing is enabled, and presents the oldest entry show-ahead to a valid/ready consumer.
module instr_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     trace_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [CYC_W-1:0] cyc_mem   [DEPTH];

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic capture, pop, push, drop, full;

    always_comb begin
        capture    = trace_en && (pc_in != last_pc_q);
        full       = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) && out_ready;
        // A full buffer still accepts a capture when the head leaves in the same cycle.
        push       = capture && (!full || pop);
        drop       = capture && full && !pop;

        cyc_d      = cyc_q + CYC_W'(1);
        last_pc_d  = capture ? pc_in : last_pc_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q || drop;
        drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q      <= '0;
            last_pc_q  <= 32'hFFFF_FFFF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cyc_q      <= cyc_d;
            last_pc_q  <= last_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately left unreset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]    <= pc_in;
            instr_mem[wr_ptr_q] <= instr_in;
            cyc_mem[wr_ptr_q]   <= cyc_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign out_cycle = cyc_mem[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Scoreboard bench for instr_trace_buffer: directed stimulus queues expected entries,
// a negedge monitor pops and compares every accepted head entry.
module tb_instr_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CYC_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cyc;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       pc_in = '0;
    logic [31:0]       instr_in = '0;
    logic              trace_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic [CYC_W-1:0]  out_cycle;
    logic [4:0]        count;
    logic              overflow;
    logic [15:0]       drop_cnt;

    entry_t exp_q[$];
    entry_t mon_e;
    int     n_checks = 0;
    int     n_fail = 0;

    instr_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .trace_en  (trace_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_cycle (out_cycle),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h cyc=%0d, required no entry",
                         out_pc, out_instr, out_cycle);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e.pc || out_instr !== mon_e.instr || out_cycle !== mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL pop_entry: got pc=%h instr=%h cyc=%0d, required pc=%h instr=%h cyc=%0d",
                             out_pc, out_instr, out_cycle, mon_e.pc, mon_e.instr, mon_e.cyc);
                end
            end
        end
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return 32'h0000_0013 ^ (pc << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] cyc);
        entry_t e;
        e.pc = pc;
        e.instr = instr;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Inputs for the current cycle, then advance to just after the next rising edge.
    task automatic step(input logic en, input logic [31:0] pc, input logic [31:0] instr, input logic rdy);
        trace_en  = en;
        pc_in     = pc;
        instr_in  = instr;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset (cycle counter reads 0).
    task automatic do_reset();
        trace_en  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        trace_en  = 1'b0;
        out_ready = 1'b1;
        while (count != 0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk({name, "_empty"}, 32'(count), 32'd0);
        chk({name, "_q_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single entry from a held PC, one-cycle visibility, idle out_ready ignored.
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        expect_entry(32'h0, 32'h0050_0513, 32'd0);
        step(1'b1, 32'h0, 32'h0050_0513, 1'b0);
        chk("t1_valid_cyc1", 32'(out_valid), 32'd1);
        step(1'b1, 32'h0, 32'h0050_0513, 1'b0);
        step(1'b1, 32'h0, 32'h0050_0513, 1'b0);
        chk("t1_count", 32'(count), 32'd1);
        drain("t1_drain");
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t1_idle_count", 32'(count), 32'd0);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);

        // Repeated PC suppressed; stamps follow capture cycles.
        do_reset();
        expect_entry(32'h0, mk_instr(32'h0), 32'd0);
        expect_entry(32'h4, mk_instr(32'h4), 32'd1);
        expect_entry(32'h8, mk_instr(32'h8), 32'd2);
        expect_entry(32'hC, mk_instr(32'hC), 32'd4);
        step(1'b1, 32'h0, mk_instr(32'h0), 1'b0);
        step(1'b1, 32'h4, mk_instr(32'h4), 1'b0);
        step(1'b1, 32'h8, mk_instr(32'h8), 1'b0);
        step(1'b1, 32'h8, mk_instr(32'h8), 1'b0);
        step(1'b1, 32'hC, mk_instr(32'hC), 1'b0);
        chk("t2_count", 32'(count), 32'd4);
        drain("t2_drain");

        // Overflow: 20 PCs into 16 slots.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_entry(32'(i * 4), mk_instr(32'(i * 4)), 32'(i));
            step(1'b1, 32'(i * 4), mk_instr(32'(i * 4)), 1'b0);
        end
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_cnt), 32'd4);
        drain("t3_drain");
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Full buffer with simultaneous capture and pop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            expect_entry(32'(i * 4), mk_instr(32'(i * 4)), 32'(i));
            step(1'b1, 32'(i * 4), mk_instr(32'(i * 4)), 1'b0);
        end
        chk("t4_full", 32'(count), 32'd16);
        expect_entry(32'h100, mk_instr(32'h100), 32'd16);
        step(1'b1, 32'h100, mk_instr(32'h100), 1'b1);
        chk("t4_count_kept", 32'(count), 32'd16);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_drop", 32'(drop_cnt), 32'd0);
        drain("t4_drain");

        // Disabled tracing does not update last PC.
        do_reset();
        step(1'b0, 32'h0, mk_instr(32'h0), 1'b0);
        step(1'b0, 32'h4, mk_instr(32'h4), 1'b0);
        expect_entry(32'h4, mk_instr(32'h4), 32'd2);
        step(1'b1, 32'h4, mk_instr(32'h4), 1'b0);
        step(1'b1, 32'h4, mk_instr(32'h4), 1'b0);
        step(1'b1, 32'h4, mk_instr(32'h4), 1'b0);
        chk("t5_count", 32'(count), 32'd1);
        drain("t5_drain");

        // Reset mid-stream with count=5 and overflow set.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_entry(32'(i * 4), mk_instr(32'(i * 4)), 32'(i));
            step(1'b1, 32'(i * 4), mk_instr(32'(i * 4)), 1'b0);
        end
        for (int i = 0; i < 11; i++) step(1'b0, 32'h40, 32'h0, 1'b1);
        out_ready = 1'b0;
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_overflow", 32'(overflow), 32'd1);
        exp_q.delete();
        do_reset();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        expect_entry(32'h40, mk_instr(32'h40), 32'd0);
        step(1'b1, 32'h40, mk_instr(32'h40), 1'b0);
        chk("t6_recapture_valid", 32'(out_valid), 32'd1);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_trace_buffer.md
INSTR_TRACE_BUFFER -- requirements
Module: instr_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of trace entries; power of two, minimum 2.
REQ-002 SHALL have parameter CYC_W, default 32, meaning width of the cycle-stamp counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_in  input  32  core PC (the core's pc_out).
REQ-006 SHALL have port instr_in  input  32  core instruction (the core's instr_out).
REQ-007 SHALL have port trace_en  input  1  capture enable.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port out_pc  output  32  head entry PC.
REQ-011 SHALL have port out_instr  output  32  head entry instruction.
REQ-012 SHALL have port out_cycle  output  CYC_W  head entry cycle stamp.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-014 SHALL have port overflow  output  1  sticky: at least one entry dropped.
REQ-015 SHALL have port drop_cnt  output  16  dropped entries, saturating.

Function
REQ-016 SHALL maintain free-running cycle counter cyc: 0 in the first cycle after reset, +1 every cycle, wraps modulo 2^CYC_W.
REQ-017 SHALL hold register last_pc, reset value 32'hFFFFFFFF.
REQ-018 SHALL raise capture event in a cycle iff trace_en=1 and pc_in != last_pc.
REQ-019 SHALL, on a capture event, update last_pc to pc_in, whether or not the entry is stored.
REQ-020 SHALL leave last_pc unchanged while trace_en=0.
REQ-021 SHALL form a captured entry as {pc_in, instr_in, cyc} sampled in the capture cycle.
REQ-022 SHALL store entries in a circular FIFO with wr_ptr and rd_ptr wrapping modulo DEPTH.
REQ-023 SHALL be show-ahead: out_valid = (count != 0); out_pc, out_instr and out_cycle reflect the head entry combinationally from storage.
REQ-024 SHALL pop on out_valid && out_ready at the clock edge.
REQ-025 SHALL make an entry captured in cycle N visible with out_valid=1 in cycle N+1 (one-cycle latency).
REQ-026 SHALL, with count=0 and no capture, ignore out_ready with no state change.
REQ-027 SHALL, with count=DEPTH, capture event and pop in the same cycle, store the entry and keep count at DEPTH.
REQ-028 SHALL, with count=DEPTH, capture event and no pop, drop the entry, set overflow=1 and increment drop_cnt, saturating at 16'hFFFF.
REQ-029 SHALL, on simultaneous push and pop at 0<count<DEPTH, leave count unchanged.
REQ-030 SHALL ensure out_pc, out_instr and out_cycle are don't-care while out_valid=0; the bench must not check them.
REQ-031 SHALL keep overflow set until reset.

Reset
REQ-032 SHALL, with reset=1 at a rising edge, clear count, wr_ptr, rd_ptr, cyc, overflow and drop_cnt to 0 and set last_pc to 32'hFFFFFFFF; out_valid=0 in the following cycle.
REQ-033 SHALL give reset priority over capture and pop in the same cycle; reset mid-stream discards all stored entries.
REQ-034 SHALL NOT require storage array contents to be reset.

Verification
REQ-035 Release reset; trace_en=1; pc_in=0x0, instr_in=0x00500513 held for 3 cycles -> exactly one entry {0x0, 0x00500513, cyc=0}, out_valid=1 in cycle 1.
REQ-036 pc_in sequence 0x0, 0x4, 0x8, 0x8, 0xC with out_ready=0 -> count=4; drain with out_ready=1 -> PCs 0x0, 0x4, 0x8, 0xC in order with increasing cycle stamps.
REQ-037 DEPTH=16, out_ready=0, 20 distinct PCs -> count=16, overflow=1, drop_cnt=4; drain -> the first 16 PCs in order.
REQ-038 Full FIFO, new PC and out_ready=1 in the same cycle -> count stays 16, overflow stays 0, the new entry appears last.
REQ-039 trace_en=0 while PC changes 0x0->0x4, then trace_en=1 with pc_in=0x4 -> one entry pc=0x4; then pc_in=0x4 held -> no further entries.
REQ-040 Assert reset with count=5 and overflow=1, then deassert -> count=0, out_valid=0, overflow=0, drop_cnt=0, cyc restarts at 0; first capture recorded even if pc_in equals the pre-reset last PC.
